// File: rtl/pipelined_addsub.sv
// Chunked ripple-carry adder/subtractor pipelined one CHUNK per stage, with
// optional signed saturation and registered flags on the final stage.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALUC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             CF,
    output logic             OF,
    output logic             ZF,
    output logic             NF
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    // Handshake: a transfer happens on valid & ready at a rising edge. The whole
    // pipeline advances together when the output slot is empty or being drained.
    logic adv;

    // Per-stage registers; b_q holds B already conditionally inverted.
    logic             v_q    [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic [WIDTH-1:0] r_q    [STAGES];
    logic             c_q    [STAGES];
    logic [1:0]       aluc_q [STAGES];

    // Inputs seen by each stage and the values it will register.
    logic             src_v    [STAGES];
    logic [WIDTH-1:0] src_a    [STAGES];
    logic [WIDTH-1:0] src_b    [STAGES];
    logic [WIDTH-1:0] src_r    [STAGES];
    logic             src_c    [STAGES];
    logic [1:0]       src_aluc [STAGES];
    logic [WIDTH-1:0] r_d      [STAGES];
    logic             c_d      [STAGES];
    logic [CHUNK:0]   part;

    logic [WIDTH-1:0] s_q, s_d, sat;
    logic             cf_q, cf_d, of_q, of_d, zf_q, zf_d, nf_q, nf_d;
    logic [WIDTH-1:0] r_fin;

    assign adv       = out_ready | ~v_q[LAST];
    assign in_ready  = adv;
    assign out_valid = v_q[LAST];
    assign S         = s_q;
    assign CF        = cf_q;
    assign OF        = of_q;
    assign ZF        = zf_q;
    assign NF        = nf_q;

    always_comb begin
        part = '0;
        for (int k = 0; k < STAGES; k++) begin
            src_v[k]    = 1'b0;
            src_a[k]    = '0;
            src_b[k]    = '0;
            src_r[k]    = '0;
            src_c[k]    = 1'b0;
            src_aluc[k] = '0;
            r_d[k]      = '0;
            c_d[k]      = 1'b0;
        end

        src_v[0]    = in_valid;
        src_a[0]    = A;
        src_b[0]    = ALUC[0] ? ~B : B;
        src_r[0]    = '0;
        src_c[0]    = ALUC[0];
        src_aluc[0] = ALUC;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]    = v_q[k-1];
            src_a[k]    = a_q[k-1];
            src_b[k]    = b_q[k-1];
            src_r[k]    = r_q[k-1];
            src_c[k]    = c_q[k-1];
            src_aluc[k] = aluc_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src_c[k]};
            r_d[k] = src_r[k];
            r_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            c_d[k] = part[CHUNK];
        end

        // Flags use the raw sum; ZF/NF follow the possibly saturated result.
        r_fin = r_d[LAST];
        cf_d  = c_d[LAST] ^ src_aluc[LAST][0];
        of_d  = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &
                (r_fin[WIDTH-1] != src_a[LAST][WIDTH-1]);
        sat   = src_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        s_d   = (src_aluc[LAST][1] & of_d) ? sat : r_fin;
        zf_d  = (s_d == '0);
        nf_d  = s_d[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]    <= 1'b0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                r_q[k]    <= '0;
                c_q[k]    <= 1'b0;
                aluc_q[k] <= '0;
            end
            s_q  <= '0;
            cf_q <= 1'b0;
            of_q <= 1'b0;
            zf_q <= 1'b0;
            nf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]    <= src_v[k];
                a_q[k]    <= src_a[k];
                b_q[k]    <= src_b[k];
                r_q[k]    <= r_d[k];
                c_q[k]    <= c_d[k];
                aluc_q[k] <= src_aluc[k];
            end
            s_q  <= s_d;
            cf_q <= cf_d;
            of_q <= of_d;
            zf_q <= zf_d;
            nf_q <= nf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, stall/reset sequences and
// randomized streams for the 32/8, 16/4 and 8/8 configurations.
module tb_pipelined_addsub;

    logic clk;
    logic rst_n;

    logic        iv, ir, ov, ordy, cf, of, zf, nf;
    logic [31:0] a, b, s;
    logic [1:0]  aluc;

    logic        iv_h, ir_h, ov_h, ordy_h, cf_h, of_h, zf_h, nf_h;
    logic [15:0] a_h, b_h, s_h;
    logic [1:0]  aluc_h;

    logic        iv_e, ir_e, ov_e, ordy_e, cf_e, of_e, zf_e, nf_e;
    logic [7:0]  a_e, b_e, s_e;
    logic [1:0]  aluc_e;

    int checks;
    int failures;
    int cyc;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  aluc;
        logic [35:0] exp;
    } vec_t;

    vec_t vt [10];

    logic [35:0] exp_q   [$];
    logic [35:0] exp_h_q [$];
    logic [35:0] exp_e_q [$];
    int          acc_h_q [$];
    int          acc_e_q [$];

    pipelined_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
        .A(a), .B(b), .ALUC(aluc), .out_valid(ov), .out_ready(ordy),
        .S(s), .CF(cf), .OF(of), .ZF(zf), .NF(nf)
    );

    pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_h), .in_ready(ir_h),
        .A(a_h), .B(b_h), .ALUC(aluc_h), .out_valid(ov_h), .out_ready(ordy_h),
        .S(s_h), .CF(cf_h), .OF(of_h), .ZF(zf_h), .NF(nf_h)
    );

    pipelined_addsub #(.WIDTH(8), .CHUNK(8)) dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_e), .in_ready(ir_e),
        .A(a_e), .B(b_e), .ALUC(aluc_e), .out_valid(ov_e), .out_ready(ordy_e),
        .S(s_e), .CF(cf_e), .OF(of_e), .ZF(zf_e), .NF(nf_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: signed/unsigned arithmetic on integers, then clamp.
    function automatic logic [35:0] model(input logic [31:0] av, input logic [31:0] bv,
                                          input logic [1:0] op, input int w);
        longint m, half, ua, ub, sa, sb, sr, ur, res;
        logic   c_f, o_f, z_f, n_f;
        logic [31:0] s32;
        m    = longint'(1) << w;
        half = m >> 1;
        ua   = longint'(av);
        ub   = longint'(bv);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        sr   = op[0] ? sa - sb : sa + sb;
        ur   = op[0] ? ua - ub : ua + ub;
        o_f  = (sr >= half) || (sr < -half);
        c_f  = op[0] ? (ua < ub) : (ur >= m);
        res  = ur & (m - 1);
        if (op[1] && o_f) res = (sr >= half) ? half - 1 : half;
        z_f  = (res == 0);
        n_f  = ((res >> (w - 1)) & 1) != 0;
        s32  = res[31:0];
        return {s32, c_f, o_f, z_f, n_f};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic sb_pop(input string name, input logic [35:0] act);
        if (exp_q.size() == 0) chk({name, "_unexpected"}, 64'(act), 64'hdead);
        else chk(name, 64'(act), 64'(exp_q.pop_front()));
    endtask

    task automatic run_single(input vec_t v);
        int lat;
        a = v.a; b = v.b; aluc = v.aluc; iv = 1'b1; ordy = 1'b1;
        #1 chk("single_in_ready", 64'(ir), 64'd1);
        step();
        iv = 1'b0;
        lat = 1;
        #1;
        while (!ov && lat < 20) begin
            step();
            lat++;
            #1;
        end
        chk("single_latency", 64'(lat), 64'd4);
        chk("single_result", 64'({s, cf, of, zf, nf}), 64'(v.exp));
        step();
        #1 chk("single_drained", 64'(ov), 64'd0);
    endtask

    initial begin
        logic [35:0] held;
        logic        prev_hold;
        int n_sent, n_got, last_cyc, n_h, n_e, got_h, got_e;

        checks = 0; failures = 0; cyc = 0;
        vt[0] = '{32'hFFFFFFFF, 32'h00000001, 2'b00, {32'h00000000, 4'b1010}};
        vt[1] = '{32'h00000000, 32'h00000001, 2'b01, {32'hFFFFFFFF, 4'b1001}};
        vt[2] = '{32'h80000000, 32'h00000001, 2'b11, {32'h80000000, 4'b0101}};
        vt[3] = '{32'h7FFFFFFF, 32'h00000001, 2'b10, {32'h7FFFFFFF, 4'b0100}};
        vt[4] = '{32'h7FFFFFFF, 32'h00000001, 2'b00, {32'h80000000, 4'b0101}};
        vt[5] = '{32'h80000000, 32'h80000000, 2'b10, {32'h80000000, 4'b1101}};
        vt[6] = '{32'h00000005, 32'h00000005, 2'b11, {32'h00000000, 4'b0010}};
        vt[7] = '{32'h00000100, 32'h000000FF, 2'b01, {32'h00000001, 4'b0000}};
        vt[8] = '{32'h000000FF, 32'h00000001, 2'b00, {32'h00000100, 4'b0000}};
        vt[9] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 2'b11, {32'h7FFFFFFF, 4'b1100}};

        rst_n = 1'b0;
        iv = 0; a = 0; b = 0; aluc = 0; ordy = 1;
        iv_h = 0; a_h = 0; b_h = 0; aluc_h = 0; ordy_h = 1;
        iv_e = 0; a_e = 0; b_e = 0; aluc_e = 0; ordy_e = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(ov), 64'd0);
        chk("reset_in_ready", 64'(ir), 64'd1);
        chk("reset_outputs", 64'({s, cf, of, zf, nf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_single(vt[i]);

        // 16 back-to-back operations with a 4-cycle consumer stall.
        n_sent = 0; n_got = 0; last_cyc = -1; held = '0;
        for (int c = 0; c < 40; c++) begin
            iv   = (n_sent < 16);
            a    = $urandom; b = $urandom; aluc = 2'($urandom_range(0, 3));
            ordy = !(c >= 6 && c <= 9);
            #1;
            if (c >= 6 && c <= 9) begin
                chk("stall_in_ready", 64'(ir), 64'd0);
                if (c == 6) held = {s, cf, of, zf, nf};
                else chk("stall_hold", 64'({s, cf, of, zf, nf}), 64'(held));
            end
            if (iv && ir) begin
                exp_q.push_back(model(a, b, aluc, 32));
                n_sent++;
            end
            if (ov && ordy) begin
                sb_pop("stream_result", {s, cf, of, zf, nf});
                n_got++;
                last_cyc = c;
            end
            step();
        end
        iv = 0;
        chk("stream_count", 64'(n_got), 64'd16);
        chk("stream_last_cycle", 64'(last_cyc), 64'd23);

        // Random traffic with random back-pressure on the 32-bit instance.
        prev_hold = 1'b0;
        for (int c = 0; c < 300; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            a    = $urandom; b = $urandom; aluc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) b = a;
            #1;
            if (prev_hold) begin
                chk("rand_hold_valid", 64'(ov), 64'd1);
                chk("rand_hold_data", 64'({s, cf, of, zf, nf}), 64'(held));
            end
            prev_hold = ov && !ordy;
            held = {s, cf, of, zf, nf};
            if (iv && ir) exp_q.push_back(model(a, b, aluc, 32));
            if (ov && ordy) sb_pop("rand_result", {s, cf, of, zf, nf});
            step();
        end
        iv = 0; ordy = 1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            #1;
            if (ov) sb_pop("rand_drain", {s, cf, of, zf, nf});
            step();
        end
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset with operations in flight.
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv = 1'b1; a = $urandom; b = $urandom; aluc = 2'($urandom_range(0, 3));
            step();
        end
        iv = 1'b0;
        step();
        #1 chk("pre_reset_valid", 64'(ov), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", 64'(ov), 64'd0);
        chk("mid_reset_outputs", 64'({s, cf, of, zf, nf}), 64'd0);
        chk("mid_reset_in_ready", 64'(ir), 64'd1);
        step();
        rst_n = 1'b1;
        ordy  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            #1 chk("post_reset_no_stale", 64'(ov), 64'd0);
        end
        run_single(vt[2]);

        // 1000 random vectors on the 16/4 and 8/8 instances.
        n_h = 0; n_e = 0; got_h = 0; got_e = 0;
        ordy_h = 1'b1; ordy_e = 1'b1;
        for (int c = 0; c < 3000 && (got_h < 1000 || got_e < 1000); c++) begin
            iv_h = (n_h < 1000) && ($urandom_range(0, 3) != 0);
            iv_e = (n_e < 1000) && ($urandom_range(0, 3) != 0);
            a_h = 16'($urandom); b_h = 16'($urandom); aluc_h = 2'($urandom_range(0, 3));
            a_e = 8'($urandom);  b_e = 8'($urandom);  aluc_e = 2'($urandom_range(0, 3));
            #1;
            if (iv_h && ir_h) begin
                exp_h_q.push_back(model({16'h0, a_h}, {16'h0, b_h}, aluc_h, 16));
                acc_h_q.push_back(cyc);
                n_h++;
            end
            if (iv_e && ir_e) begin
                exp_e_q.push_back(model({24'h0, a_e}, {24'h0, b_e}, aluc_e, 8));
                acc_e_q.push_back(cyc);
                n_e++;
            end
            if (ov_h) begin
                if (exp_h_q.size() == 0) chk("w16_unexpected", 64'(s_h), 64'hdead);
                else begin
                    chk("w16_result", 64'({16'h0, s_h, cf_h, of_h, zf_h, nf_h}),
                        64'(exp_h_q.pop_front()));
                    chk("w16_latency", 64'(cyc - acc_h_q.pop_front()), 64'd4);
                end
                got_h++;
            end
            if (ov_e) begin
                if (exp_e_q.size() == 0) chk("w8_unexpected", 64'(s_e), 64'hdead);
                else begin
                    chk("w8_result", 64'({24'h0, s_e, cf_e, of_e, zf_e, nf_e}),
                        64'(exp_e_q.pop_front()));
                    chk("w8_latency", 64'(cyc - acc_e_q.pop_front()), 64'd1);
                end
                got_e++;
            end
            step();
        end
        iv_h = 0; iv_e = 0;
        chk("w16_count", 64'(got_h), 64'd1000);
        chk("w8_count", 64'(got_e), 64'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, meaning bits per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK; STAGES = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the operands on A, B and ALUC are valid.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the operands this cycle.
REQ-007 The block SHALL have port A, input, WIDTH, meaning operand A.
REQ-008 The block SHALL have port B, input, WIDTH, meaning operand B.
REQ-009 The block SHALL have port ALUC, input, 2, meaning the operation: bit0 = 1 subtract (A-B), 0 add; bit1 = 1 signed saturating, 0 wrapping.
REQ-010 The block SHALL have port out_valid, output, 1, meaning S and the flags are valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-012 The block SHALL have port S, output, WIDTH, meaning the result.
REQ-013 The block SHALL have ports CF, OF, ZF and NF, each output, 1, meaning carry/borrow, signed overflow, zero and negative flags.

Function
REQ-014 The datapath SHALL be a STAGES-deep pipeline; stage k SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of A and the conditionally inverted B, using the carry registered by stage k-1.
- Carry-in of stage 0 SHALL be ALUC[0].
- B SHALL be inverted when ALUC[0]=1.
REQ-015 Higher operand chunks and ALUC SHALL be carried forward in registers alongside the partial sum.
REQ-016 Latency SHALL be exactly STAGES cycles: an accept at edge N SHALL give out_valid=1 after edge N+STAGES-1 when there are no stalls.
REQ-017 A transfer SHALL occur on in_valid & in_ready, and on out_valid & out_ready.
REQ-018 There SHALL be a global advance enable adv = out_ready | ~out_valid; when adv=0, all pipeline registers, including the valid bits, SHALL hold.
REQ-019 in_ready SHALL equal adv.
- Back-to-back accepts SHALL give a throughput of 1 result per cycle.
- Bubbles (in_valid=0) SHALL propagate as valid=0 stages.
REQ-020 Raw flags SHALL be computed from the final full-width sum R and carry-out C.
- CF = C XOR ALUC[0], i.e. borrow on subtract.
- OF = (A[W-1]==B'[W-1]) & (R[W-1]!=A[W-1]), where B' is B after conditional inversion.
REQ-021 When ALUC[1]=0, S SHALL be R.
REQ-022 When ALUC[1]=1 and OF=1, S SHALL be the signed saturation value:
- A[W-1]=0 gives 0111..1.
- A[W-1]=1 gives 1000..0.
REQ-023 When ALUC[1]=1 and OF=0, S SHALL be R.
REQ-024 In every mode, ZF = (S==0) and NF = S[W-1], both computed on the final S.
- CF and OF SHALL always report the unsaturated raw values.
REQ-025 Outputs S, CF, OF, ZF and NF SHALL be registered and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Simultaneous output drain and input accept in the same cycle SHALL lose no data and duplicate no data.

Reset
REQ-027 Assertion of rst_n=0 SHALL asynchronously clear all stage valid bits, out_valid, S, CF, OF, ZF and NF to 0.
REQ-028 During reset, in_ready SHALL be 1 (out_valid=0), but no transfer SHALL occur while rst_n=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations; the first result after release SHALL come from the first post-release accept.
REQ-030 Release of rst_n SHALL be synchronised by the integrator; the block SHALL be correct from the first clock edge after deassertion.

Verification
REQ-031 WIDTH=32, CHUNK=8, ALUC=00, A=FFFFFFFF, B=00000001 -> after 4 cycles: S=00000000, CF=1, OF=0, ZF=1, NF=0.
REQ-032 ALUC=01, A=00000000, B=00000001 -> S=FFFFFFFF, CF=1 (borrow), OF=0, NF=1; ALUC=11, A=80000000, B=00000001 -> S=80000000, OF=1, CF=0.
REQ-033 ALUC=10, A=7FFFFFFF, B=00000001 -> S=7FFFFFFF, OF=1, NF=0; the same operands with ALUC=00 -> S=80000000, OF=1, NF=1.
REQ-034 Stream 16 random operations back-to-back while holding out_ready=0 for cycles 6-9 -> in_ready=0 during the stall, results in order, none lost or duplicated, 1 result per cycle otherwise.
REQ-035 Accept 3 operations, then assert rst_n=0 for 1 cycle -> out_valid=0 immediately and no stale results after release.
REQ-036 WIDTH=16, CHUNK=4 and WIDTH=8, CHUNK=8 (STAGES=1) -> 1000 random vectors match the reference model at latencies 4 and 1.
